// File: rtl/host_stream_ctrl.sv
// host_stream_ctrl
//   Byte-level sequencer between the UART and the MAC compute engine.
//   After reset/reload the first NUM_WEIGHTS received bytes are written to
//   the weight buffer. Every byte after that is a pixel that starts one
//   compute. The result is saturated to 8 bits and sent to the UART
//   transmitter. Bytes arriving while a pixel is in flight are dropped and
//   raise a sticky overrun flag.
// Ports
//   clk, reset_n              : clock, async active-low reset
//   rx_valid, rx_data         : received byte strobe and data
//   reload                    : restart the weight load
//   w_we, w_addr, w_data      : weight buffer write port (registered)
//   px_valid, px_data         : pixel strobe to the compute engine
//   res_valid, res_data       : compute result from the engine
//   tx_start, tx_data, tx_busy: UART transmitter handshake
//   weights_loaded, overrun   : status flags
//   state_o                   : current FSM state (debug)
module host_stream_ctrl #(
  parameter int NUM_WEIGHTS = 64,
  parameter int ADDR_W      = 6,
  parameter int RES_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              reload,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_addr,
  output logic [7:0]        w_data,
  output logic              px_valid,
  output logic [7:0]        px_data,
  input  logic              res_valid,
  input  logic [RES_W-1:0]  res_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              weights_loaded,
  output logic              overrun,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    LOAD_W  = 3'd0,
    IDLE    = 3'd1,
    COMPUTE = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHTS - 1);
  localparam logic [RES_W-1:0]  SAT_MAX   = RES_W'(255);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              w_we_q, w_we_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              px_valid_q, px_valid_d;
  logic [7:0]        px_data_q, px_data_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              loaded_q, loaded_d;
  logic              ovr_q, ovr_d;
  // WAIT_TX must see the transmitter go busy before it may see it go idle,
  // because tx_busy only rises the cycle after tx_start.
  logic              busy_seen_q, busy_seen_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_we_d      = 1'b0;
    w_addr_d    = w_addr_q;
    w_data_d    = w_data_q;
    px_valid_d  = 1'b0;
    px_data_d   = px_data_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    loaded_d    = loaded_q;
    ovr_d       = ovr_q;
    busy_seen_d = busy_seen_q;

    if (reload) begin
      // Wins over everything, including a byte in the same cycle; the
      // pulse defaults above suppress any pending px/tx strobe.
      state_d     = LOAD_W;
      cnt_d       = '0;
      loaded_d    = 1'b0;
      ovr_d       = 1'b0;
      busy_seen_d = 1'b0;
    end else begin
      case (state_q)
        LOAD_W: if (rx_valid) begin
          w_we_d   = 1'b1;
          w_addr_d = cnt_q;
          w_data_d = rx_data;
          if (cnt_q == LAST_ADDR) begin
            cnt_d    = '0;
            loaded_d = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        IDLE: if (rx_valid) begin
          px_valid_d = 1'b1;
          px_data_d  = rx_data;
          state_d    = COMPUTE;
        end
        COMPUTE: if (res_valid) begin
          tx_data_d = (res_data > SAT_MAX) ? 8'hFF : res_data[7:0];
          state_d   = SEND;
        end
        SEND: if (!tx_busy) begin
          tx_start_d  = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_busy)               busy_seen_d = 1'b1;
          else if (busy_seen_q)      state_d     = IDLE;
        end
        default: state_d = LOAD_W;
      endcase

      if (rx_valid && (state_q == COMPUTE || state_q == SEND || state_q == WAIT_TX))
        ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LOAD_W;
      cnt_q       <= '0;
      w_we_q      <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      px_valid_q  <= 1'b0;
      px_data_q   <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      loaded_q    <= 1'b0;
      ovr_q       <= 1'b0;
      busy_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      w_we_q      <= w_we_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      px_valid_q  <= px_valid_d;
      px_data_q   <= px_data_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      loaded_q    <= loaded_d;
      ovr_q       <= ovr_d;
      busy_seen_q <= busy_seen_d;
    end
  end

  assign w_we           = w_we_q;
  assign w_addr         = w_addr_q;
  assign w_data         = w_data_q;
  assign px_valid       = px_valid_q;
  assign px_data        = px_data_q;
  assign tx_start       = tx_start_q;
  assign tx_data        = tx_data_q;
  assign weights_loaded = loaded_q;
  assign overrun        = ovr_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_host_stream_ctrl.sv
// Bench for host_stream_ctrl. The reference is transaction level: queues of
// expected weight writes, pixels and transmitted bytes, filled by the
// stimulus tasks from the protocol rules and drained by a monitor.
module tb_host_stream_ctrl;
  localparam int NW = 64;
  localparam int AW = 6;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx_valid = 1'b0, reload = 1'b0, res_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic [RW-1:0] res_data = '0;
  logic          uart_busy = 1'b0, busy_ext = 1'b0;
  logic          tx_busy;
  logic          w_we, px_valid, tx_start, weights_loaded, overrun;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_data, px_data, tx_data;
  logic [2:0]    state_o;

  assign tx_busy = uart_busy | busy_ext;

  host_stream_ctrl #(.NUM_WEIGHTS(NW), .ADDR_W(AW), .RES_W(RW)) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .reload(reload), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .px_valid(px_valid), .px_data(px_data), .res_valid(res_valid),
    .res_data(res_data), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .weights_loaded(weights_loaded), .overrun(overrun),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int wq[$], pq[$], tq[$];
  int w_cnt = 0, px_cnt = 0, tx_cnt = 0;
  int last_tx = 0, e;
  bit exp_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) if (reset_n) begin
    if (w_we | px_valid | tx_start)
      chk("one_pulse", int'(w_we) + int'(px_valid) + int'(tx_start), 1);
    if (w_we) begin
      if (wq.size() == 0) chk("w_unexpected", 1, 0);
      else begin
        e = wq.pop_front();
        chk("w_addr", w_addr, e >> 8);
        chk("w_data", w_data, e & 255);
        chk("w_loaded", weights_loaded, ((e >> 8) == NW - 1) ? 1 : 0);
      end
      w_cnt++;
    end
    if (px_valid) begin
      if (pq.size() == 0) chk("px_unexpected", 1, 0);
      else chk("px_data", px_data, pq.pop_front());
      px_cnt++;
    end
    if (tx_start) begin
      if (tq.size() == 0) chk("tx_unexpected", 1, 0);
      else chk("tx_data", tx_data, tq.pop_front());
      last_tx = tx_data;
      tx_cnt++;
    end else if (state_o == 3'd4) chk("tx_hold", tx_data, last_tx);
  end

  // UART transmitter model: busy from the cycle after tx_start for a while.
  initial forever begin
    @(posedge clk); #1;
    if (tx_start) begin
      uart_busy = 1'b1;
      repeat ($urandom_range(2, 10)) @(posedge clk);
      #1 uart_busy = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b;
    step(1);
    rx_valid = 1'b0;
    step(gap);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    for (int i = 0; i < 60 && state_o != s; i++) step(1);
    chk(tag, state_o, s);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wq.delete(); pq.delete(); tq.delete();
    exp_ovr = 0;
    #1;
    chk("rst_w_we", w_we, 0);        chk("rst_w_addr", w_addr, 0);
    chk("rst_w_data", w_data, 0);    chk("rst_px_valid", px_valid, 0);
    chk("rst_px_data", px_data, 0);  chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);  chk("rst_loaded", weights_loaded, 0);
    chk("rst_overrun", overrun, 0);  chk("rst_state", state_o, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic load_weights(input int n, input bit seq);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(i + 1) : 8'($urandom_range(0, 255));
      wq.push_back((i << 8) | int'(b));
      send_byte(b, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end
    step(2);
    chk("w_drain", wq.size(), 0);
  endtask

  task automatic pulse_reload(input bit with_rx);
    reload = 1'b1;
    if (with_rx) begin rx_valid = 1'b1; rx_data = 8'hA5; end
    step(1);
    reload = 1'b0; rx_valid = 1'b0;
    wq.delete(); pq.delete(); tq.delete();
    exp_ovr = 0;
    chk("rl_state", state_o, 0);
    chk("rl_loaded", weights_loaded, 0);
    chk("rl_overrun", overrun, 0);
  endtask

  task automatic do_pixel(input logic [7:0] p, input int r, input bit ovr, input bit hold);
    int n;
    n = px_cnt;
    pq.push_back(p);
    send_byte(p, 0);
    for (int i = 0; i < 10 && px_cnt == n; i++) step(1);
    chk("px_seen", px_cnt, n + 1);
    chk("st_compute", state_o, 2);
    if (ovr) begin
      send_byte(8'h55, 0);
      exp_ovr = 1;
      chk("ovr_set", overrun, 1);
    end
    if (hold) busy_ext = 1'b1;
    step($urandom_range(0, 3));
    n = tx_cnt;
    tq.push_back(r > 255 ? 255 : r);
    res_valid = 1'b1; res_data = RW'(r);
    step(1);
    res_valid = 1'b0;
    if (hold) begin
      step(4);
      chk("send_hold_state", state_o, 3);
      chk("send_hold_notx", tx_cnt, n);
      busy_ext = 1'b0;
    end
    for (int i = 0; i < 20 && tx_cnt == n; i++) step(1);
    chk("tx_seen", tx_cnt, n + 1);
    wait_state(3'd1, "st_idle_after_tx");
    chk("ovr_flag", overrun, exp_ovr);
  endtask

  initial begin
    int n;
    step(1);
    do_reset();

    // Weight load 1..64, then fixed result corner cases
    load_weights(NW, 1);
    chk("load_state", state_o, 1);
    chk("load_flag", weights_loaded, 1);
    do_pixel(8'd10, 10, 0, 0);
    do_pixel(8'($urandom), 300, 0, 0);
    do_pixel(8'($urandom), 255, 0, 1);
    do_pixel(8'($urandom), 0, 1, 0);
    do_pixel(8'($urandom), 256, 0, 0);
    for (int k = 0; k < 10; k++)
      do_pixel(8'($urandom), int'($urandom_range(0, 65535)) >> $urandom_range(0, 8),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));

    // A result outside COMPUTE must be ignored
    res_valid = 1'b1; res_data = 16'd77;
    step(1);
    res_valid = 1'b0;
    step(4);
    chk("stray_res_state", state_o, 1);

    // Reload while a pixel is in flight: overrun cleared, no transmit
    pq.push_back(8'd3);
    n = px_cnt;
    send_byte(8'd3, 1);
    chk("rl_px_seen", px_cnt, n + 1);
    send_byte(8'h55, 0);
    chk("rl_ovr_before", overrun, 1);
    pulse_reload(0);
    res_valid = 1'b1; res_data = 16'd9;
    step(1);
    res_valid = 1'b0;
    step(3);
    chk("rl_res_ignored", state_o, 0);

    // Reload colliding with a byte, partial load, reload, full load
    pulse_reload(1);
    step(2);
    load_weights(20, 0);
    chk("partial_loaded", weights_loaded, 0);
    pulse_reload(0);
    load_weights(NW, 0);
    chk("reload_state", state_o, 1);
    chk("reload_flag", weights_loaded, 1);
    do_pixel(8'($urandom), 1000, 0, 0);

    // Async reset while transmitting
    pq.push_back(8'd7);
    send_byte(8'd7, 1);
    tq.push_back(200);
    res_valid = 1'b1; res_data = 16'd200;
    step(1);
    res_valid = 1'b0;
    for (int i = 0; i < 20 && !(state_o == 3'd4 && tx_busy); i++) step(1);
    chk("pre_rst_wait_tx", state_o, 4);
    do_reset();
    wq.push_back(8'h3C);
    send_byte(8'h3C, 2);
    chk("post_rst_w_drain", wq.size(), 0);
    chk("post_rst_state", state_o, 0);

    step(15);
    chk("pq_drain", pq.size(), 0);
    chk("tq_drain", tq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
